lz77_decompressor: RTL and testbench

// - LZ77 decoder; the receive-side counterpart of the compressor datapath.
// - Consumes 14-bit tokens {offset[2:0], length[2:0], next_char[7:0]} and rebuilds the original byte stream.
// - Keeps a 7-byte history (search) window; emits one byte per cycle on a valid/ready stream.

---
 rtl/lz77_decompressor.sv | 150 +++++++++++++++
 tb/tb_lz77_decompressor.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_decompressor.sv
// LZ77 token decoder: rebuilds a byte stream from {offset, length, next_char} tokens using a 7-byte history.
// Optional sticky illegal-token flag on err when LZ_DECOMP_ERR_EN is defined; otherwise err is tied low.
module lz77_decompressor #(
    parameter int HIST_DEPTH = 7,
    parameter int OFF_W      = 3,
    parameter int LEN_W      = 3,
    parameter int CHAR_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OFF_W+LEN_W+CHAR_W-1:0]   tok_in,
    input  logic                            tok_valid,
    output logic                            tok_ready,
    output logic [CHAR_W-1:0]               data_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            err
);
    // state | meaning
    // IDLE  | waiting for a token, tok_ready high
    // COPY  | emitting back-reference bytes from the history window
    // LIT   | emitting the token's trailing literal
    typedef enum logic [1:0] {IDLE, COPY, LIT} state_t;

    localparam int TOK_W  = OFF_W + LEN_W + CHAR_W;
    localparam int FILL_W = $clog2(HIST_DEPTH + 1);

    state_t              state_q, state_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CHAR_W-1:0]   chr_q, chr_d;
    logic [CHAR_W-1:0]   data_q, data_d;
    logic [CHAR_W-1:0]   hist_q [HIST_DEPTH];
    logic [CHAR_W-1:0]   hist_d [HIST_DEPTH];
    logic [FILL_W-1:0]   fill_q, fill_d;

    logic [OFF_W-1:0]    tok_off;
    logic [LEN_W-1:0]    tok_len;
    logic [CHAR_W-1:0]   tok_chr;
    logic                byte_acc;

    assign tok_off  = tok_in[TOK_W-1 -: OFF_W];
    assign tok_len  = tok_in[CHAR_W +: LEN_W];
    assign tok_chr  = tok_in[CHAR_W-1:0];
    assign byte_acc = (state_q != IDLE) && out_ready;

    assign tok_ready = (state_q == IDLE);
    assign out_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign data_out  = data_q;

`ifdef LZ_DECOMP_ERR_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        len_d   = len_q;
        chr_d   = chr_q;
        data_d  = data_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
`ifdef LZ_DECOMP_ERR_EN
        err_d   = err_q;
`endif
        if (byte_acc) begin
            hist_d[0] = data_q;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            if (fill_q != FILL_W'(HIST_DEPTH)) begin
                fill_d = fill_q + 1'b1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (tok_valid) begin
                    off_d = tok_off;
                    chr_d = tok_chr;
                    // offset 0 cannot reference history, so the token degrades to its literal
                    if (tok_len != '0 && tok_off != '0) begin
                        len_d   = tok_len;
                        data_d  = hist_q[tok_off - 1'b1];
                        state_d = COPY;
                    end else begin
                        len_d   = '0;
                        data_d  = tok_chr;
                        state_d = LIT;
                    end
`ifdef LZ_DECOMP_ERR_EN
                    if (tok_len != '0 && (tok_off == '0 || FILL_W'(tok_off) > fill_q)) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            COPY: begin
                if (out_ready) begin
                    len_d = len_q - 1'b1;
                    if (len_q == LEN_W'(1)) begin
                        data_d  = chr_q;
                        state_d = LIT;
                    end else begin
                        // read from the already-shifted window so overlapping copies repeat the run
                        data_d = hist_d[off_q - 1'b1];
                    end
                end
            end
            LIT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            off_q   <= '0;
            len_q   <= '0;
            chr_q   <= '0;
            data_q  <= '0;
            fill_q  <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
`ifdef LZ_DECOMP_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            len_q   <= len_d;
            chr_q   <= chr_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
`ifdef LZ_DECOMP_ERR_EN
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_lz77_decompressor.sv
// Self-checking bench for lz77_decompressor: scoreboard of expected bytes filled on token accept.
// Honours LZ_DECOMP_ERR_EN to decide the expected err behaviour.
module tb_lz77_decompressor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] tok_in = '0;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        err;

    lz77_decompressor dut (
        .clk(clk), .rst(rst), .tok_in(tok_in), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

`ifdef LZ_DECOMP_ERR_EN
    localparam logic ERR_BUILT = 1'b1;
`else
    localparam logic ERR_BUILT = 1'b0;
`endif

    int          vec_cnt = 0;
    int          miss_cnt = 0;
    logic [13:0] tok_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  out_log [$];
    logic [7:0]  mh [7];
    int          mfill;
    logic        err_exp;
    logic        accepted;
    logic        prev_v, prev_r;
    logic [7:0]  prev_d;

    function automatic logic [13:0] tok(input logic [2:0] o, input logic [2:0] l, input logic [7:0] c);
        return {o, l, c};
    endfunction

    function automatic void mshift(input logic [7:0] b);
        for (int i = 6; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = b;
        if (mfill < 7) mfill++;
    endfunction

    function automatic void model_token(input logic [13:0] t);
        logic [2:0] o;
        logic [2:0] l;
        logic [7:0] b;
        o = t[13:11];
        l = t[10:8];
        if (ERR_BUILT && l != 0 && (o == 0 || int'(o) > mfill)) err_exp = 1'b1;
        if (l != 0 && o != 0) begin
            for (int k = 0; k < int'(l); k++) begin
                b = mh[o - 3'd1];
                exp_q.push_back(b);
                mshift(b);
            end
        end
        exp_q.push_back(t[7:0]);
        mshift(t[7:0]);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 7; i++) mh[i] = 8'h00;
        mfill = 0;
        err_exp = 1'b0;
        exp_q.delete();
        tok_q.delete();
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_d = 8'h00;
    endfunction

    task automatic run_cycle(input logic rdy);
        logic [7:0] e;
        @(negedge clk);
        out_ready = rdy;
        if (tok_q.size() > 0) begin
            tok_valid = 1'b1;
            tok_in    = tok_q[0];
        end else begin
            tok_valid = 1'b0;
        end
        #1;
        if (prev_v && !prev_r) begin
            vec_cnt++;
            if (out_valid !== 1'b1 || data_out !== prev_d) begin
                miss_cnt++;
                $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, data_out, prev_d);
            end
        end
        accepted = 1'b0;
        if (tok_valid && tok_ready) begin
            model_token(tok_q.pop_front());
            accepted = 1'b1;
        end
        if (out_valid && out_ready) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
                miss_cnt++;
                $display("FAIL extra_byte: got %h expected no byte", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    miss_cnt++;
                    $display("FAIL byte: got %h expected %h", data_out, e);
                end
            end
            out_log.push_back(data_out);
        end
        prev_v = out_valid;
        prev_r = out_ready;
        prev_d = data_out;
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n = 0;
        while ((tok_q.size() > 0 || exp_q.size() > 0 || busy) && n < budget) begin
            run_cycle(rnd ? logic'($urandom_range(3) != 0) : 1'b1);
            n++;
        end
        vec_cnt++;
        if (n >= budget) begin
            miss_cnt++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
            exp_q.delete();
            tok_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tok_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if (out_valid !== 1'b0 || tok_ready !== 1'b1 || busy !== 1'b0 || data_out !== 8'h00 || err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reset_state: got v=%b rdy=%b busy=%b d=%h err=%b expected 0 1 0 00 0",
                     out_valid, tok_ready, busy, data_out, err);
        end
    endtask

    task automatic test_literal();
        tok_q.push_back(tok(3'd0, 3'd0, 8'h41));
        run_cycle(1'b1);
        vec_cnt++;
        if (accepted !== 1'b1) begin
            miss_cnt++;
            $display("FAIL lit_accept: got %b expected 1", accepted);
        end
        run_cycle(1'b1);
        vec_cnt++;
        if (out_valid !== 1'b1) begin
            miss_cnt++;
            $display("FAIL lit_latency: got out_valid=%b expected 1", out_valid);
        end
        run_cycle(1'b1);
        vec_cnt++;
        if (tok_ready !== 1'b1 || out_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL lit_ready_back: got rdy=%b v=%b expected 1 0", tok_ready, out_valid);
        end
    endtask

    task automatic test_copy();
        logic [7:0] want [7];
        want = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43, 8'h44};
        out_log.delete();
        tok_q.push_back(tok(3'd0, 3'd0, 8'h41));
        tok_q.push_back(tok(3'd0, 3'd0, 8'h42));
        tok_q.push_back(tok(3'd0, 3'd0, 8'h43));
        tok_q.push_back(tok(3'd3, 3'd3, 8'h44));
        drain(100, 1'b0);
        vec_cnt++;
        if (out_log.size() != 7) begin
            miss_cnt++;
            $display("FAIL copy_len: got %0d expected 7", out_log.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                vec_cnt++;
                if (out_log[i] !== want[i]) begin
                    miss_cnt++;
                    $display("FAIL copy_stream[%0d]: got %h expected %h", i, out_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_overlap();
        out_log.delete();
        tok_q.push_back(tok(3'd0, 3'd0, 8'h58));
        tok_q.push_back(tok(3'd1, 3'd5, 8'h59));
        drain(100, 1'b0);
        vec_cnt++;
        if (out_log.size() != 7) begin
            miss_cnt++;
            $display("FAIL overlap_len: got %0d expected 7", out_log.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                vec_cnt++;
                if (out_log[i] !== ((i < 6) ? 8'h58 : 8'h59)) begin
                    miss_cnt++;
                    $display("FAIL overlap_stream[%0d]: got %h expected %h", i, out_log[i], (i < 6) ? 8'h58 : 8'h59);
                end
            end
        end
    endtask

    task automatic test_stall();
        tok_q.push_back(tok(3'd2, 3'd4, 8'h53));
        run_cycle(1'b1);
        run_cycle(1'b1);
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_cycle(1'b1);
        drain(100, 1'b0);
    endtask

    task automatic test_reset_mid_copy();
        logic [7:0] want [4];
        want = '{8'h51, 8'h00, 8'h00, 8'h52};
        tok_q.push_back(tok(3'd2, 3'd4, 8'h5A));
        run_cycle(1'b1);
        run_cycle(1'b1);
        run_cycle(1'b1);
        do_reset();
        vec_cnt++;
        if (out_valid !== 1'b0 || tok_ready !== 1'b1 || busy !== 1'b0 || data_out !== 8'h00) begin
            miss_cnt++;
            $display("FAIL rst_mid_copy: got v=%b rdy=%b busy=%b d=%h expected 0 1 0 00",
                     out_valid, tok_ready, busy, data_out);
        end
        out_log.delete();
        tok_q.push_back(tok(3'd0, 3'd0, 8'h51));
        tok_q.push_back(tok(3'd3, 3'd2, 8'h52));
        drain(100, 1'b0);
        vec_cnt++;
        if (out_log.size() != 4) begin
            miss_cnt++;
            $display("FAIL post_rst_len: got %0d expected 4", out_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vec_cnt++;
                if (out_log[i] !== want[i]) begin
                    miss_cnt++;
                    $display("FAIL post_rst_stream[%0d]: got %h expected %h", i, out_log[i], want[i]);
                end
            end
        end
        vec_cnt++;
        if (err !== ERR_BUILT) begin
            miss_cnt++;
            $display("FAIL post_rst_err: got %b expected %b", err, ERR_BUILT);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tok_q.push_back(tok(3'($urandom_range(7)), 3'($urandom_range(7)), 8'($urandom_range(255))));
        end
        drain(2000, 1'b1);
        vec_cnt++;
        if (err !== err_exp) begin
            miss_cnt++;
            $display("FAIL random_err: got %b expected %b", err, err_exp);
        end
    endtask

    task automatic test_err();
        do_reset();
        out_log.delete();
        tok_q.push_back(tok(3'd0, 3'd3, 8'h4B));
        drain(100, 1'b0);
        vec_cnt++;
        if (out_log.size() != 1 || out_log[0] !== 8'h4B) begin
            miss_cnt++;
            $display("FAIL off0_output: got %0d bytes first=%h expected 1 byte 4b",
                     out_log.size(), (out_log.size() > 0) ? out_log[0] : 8'hxx);
        end
        for (int i = 0; i < 3; i++) run_cycle(1'b1);
        vec_cnt++;
        if (err !== ERR_BUILT) begin
            miss_cnt++;
            $display("FAIL err_sticky: got %b expected %b", err, ERR_BUILT);
        end
        do_reset();
        vec_cnt++;
        if (err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL err_cleared: got %b expected 0", err);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_literal();
        test_copy();
        test_overlap();
        test_stall();
        test_reset_mid_copy();
        test_random();
        test_err();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
